serial_tx_arbiter: RTL and testbench

//   Shares the single serial transmitter (partida_tx/pronto_serial handshake) among N_REQ requesters
//   (sensor report sender, recepcao echo/ack sender, debug). Round-robin grant at packet granularity:
//   a winner keeps the transmitter until its byte flagged 'ultimo' is sent. Watchdog aborts stuck transfers.

---
 rtl/serial_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ requesters at packet
// granularity, with a watchdog that aborts a byte whose pronto_serial never arrives.
module serial_tx_arbiter #(
   parameter int N_REQ   = 2,
   parameter int W_DADO  = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          valid,
   input  logic [N_REQ*W_DADO-1:0]   dados,
   input  logic [N_REQ-1:0]          ultimo,
   input  logic                      pronto_serial,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          ack,
   output logic                      partida_tx,
   output logic [W_DADO-1:0]         dado_tx,
   output logic                      ocupado,
   output logic                      erro,
   output logic [3:0]                db_estado
);

   localparam int unsigned NR = N_REQ;
   localparam int OW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      CONCEDE  = 3'd1,
      PARTIDA  = 3'd2,
      ESPERA   = 3'd3,
      CONFIRMA = 3'd4,
      ERRO     = 3'd5
   } estado_t;

   estado_t           state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [OW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [W_DADO-1:0] dado_q, dado_d;
   logic              ultimo_q, ultimo_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              partida_q, partida_d;
   logic              erro_q, erro_d;
   logic              ocupado_q, ocupado_d;
   logic [3:0]        db_q, db_d;
   logic [OW-1:0]     cand;
   logic              found;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      dado_d   = dado_q;
      ultimo_d = ultimo_q;
      cand     = '0;
      found    = 1'b0;
      case (state_q)
         OCIOSO: begin
            // search starts just after the previous owner, so it is served last
            for (int unsigned k = 1; k <= NR; k++) begin
               cand = OW'((32'(last_q) + k) % NR);
               if (!found && req[cand]) begin
                  found   = 1'b1;
                  owner_d = cand;
               end
            end
            if (found) state_d = CONCEDE;
         end
         CONCEDE: begin
            if (valid[owner_q]) begin
               dado_d   = dados[owner_q*W_DADO +: W_DADO];
               ultimo_d = ultimo[owner_q];
               state_d  = PARTIDA;
            end else if (!req[owner_q]) begin
               last_d  = owner_q;
               state_d = OCIOSO;
            end
         end
         PARTIDA: begin
            cnt_d   = '0;
            state_d = ESPERA;
         end
         ESPERA: begin
            cnt_d = cnt_q + 1'b1;
            if (pronto_serial)               state_d = CONFIRMA;
            else if (cnt_d == CW'(TIMEOUT - 1)) state_d = ERRO;
         end
         CONFIRMA: begin
            if (ultimo_q) begin
               last_d  = owner_q;
               state_d = OCIOSO;
            end else begin
               state_d = CONCEDE;
            end
         end
         ERRO: begin
            last_d  = owner_q;
            state_d = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase
   end

   // outputs are decoded from the next state so the registered copies align with state_q
   always_comb begin
      gnt_d     = '0;
      ack_d     = '0;
      partida_d = 1'b0;
      erro_d    = 1'b0;
      ocupado_d = (state_d != OCIOSO);
      db_d      = 4'hF;
      case (state_d)
         OCIOSO:   db_d = 4'h0;
         CONCEDE:  begin db_d = 4'h1; gnt_d[owner_d] = 1'b1; end
         PARTIDA:  begin db_d = 4'h2; gnt_d[owner_d] = 1'b1; partida_d = 1'b1; end
         ESPERA:   begin db_d = 4'h3; gnt_d[owner_d] = 1'b1; end
         CONFIRMA: begin db_d = 4'h4; gnt_d[owner_d] = 1'b1; ack_d[owner_d] = 1'b1; end
         ERRO:     begin db_d = 4'h5; erro_d = 1'b1; end
         default:  db_d = 4'hF;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= OCIOSO;
         owner_q   <= '0;
         last_q    <= OW'(N_REQ - 1);
         cnt_q     <= '0;
         dado_q    <= '0;
         ultimo_q  <= 1'b0;
         gnt_q     <= '0;
         ack_q     <= '0;
         partida_q <= 1'b0;
         erro_q    <= 1'b0;
         ocupado_q <= 1'b0;
         db_q      <= 4'h0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         dado_q    <= dado_d;
         ultimo_q  <= ultimo_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         partida_q <= partida_d;
         erro_q    <= erro_d;
         ocupado_q <= ocupado_d;
         db_q      <= db_d;
      end
   end

   assign gnt        = gnt_q;
   assign ack        = ack_q;
   assign partida_tx = partida_q;
   assign dado_tx    = dado_q;
   assign ocupado    = ocupado_q;
   assign erro       = erro_q;
   assign db_estado  = db_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (N_REQ=2, TIMEOUT=16): single packet, contention,
// watchdog abort, withdraw, stray pronto_serial and reset during a transfer.
module tb_serial_tx_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req, valid, ultimo;
   logic [15:0] dados;
   logic        pronto_serial;
   logic [1:0]  gnt, ack;
   logic        partida_tx, ocupado, erro;
   logic [7:0]  dado_tx;
   logic [3:0]  db_estado;

   int passed = 0;
   int total  = 0;

   serial_tx_arbiter #(.N_REQ(2), .W_DADO(8), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .req(req), .valid(valid), .dados(dados),
      .ultimo(ultimo), .pronto_serial(pronto_serial), .gnt(gnt), .ack(ack),
      .partida_tx(partida_tx), .dado_tx(dado_tx), .ocupado(ocupado), .erro(erro),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // entry: DUT in CONCEDE owned by i; exit one cycle after the ack pulse
   task automatic send_byte(input int i, input logic [7:0] b, input logic last,
                            input int dly, input logic drop);
      chk("gnt_before_byte", 32'(gnt), 32'(1 << i));
      valid[i] = 1'b1; dados[i*8 +: 8] = b; ultimo[i] = last;
      tick(1);
      chk("partida_pulse", 32'(partida_tx), 32'd1);
      chk("dado_tx_latched", 32'(dado_tx), 32'(b));
      chk("db_partida", 32'(db_estado), 32'd2);
      valid = '0; ultimo = '0; dados = '0;
      tick(dly - 1);
      chk("partida_single", 32'(partida_tx), 32'd0);
      chk("db_espera", 32'(db_estado), 32'd3);
      chk("dado_tx_stable", 32'(dado_tx), 32'(b));
      pronto_serial = 1'b1;
      tick(1);
      pronto_serial = 1'b0;
      chk("ack_pulse", 32'(ack), 32'(1 << i));
      chk("gnt_in_confirma", 32'(gnt), 32'(1 << i));
      chk("no_erro", 32'(erro), 32'd0);
      if (last && drop) req[i] = 1'b0;
      tick(1);
      chk("ack_cleared", 32'(ack), 32'd0);
      chk("db_after_byte", 32'(db_estado), last ? 32'd0 : 32'd1);
   endtask

   initial begin
      reset = 1'b1; req = '0; valid = '0; ultimo = '0; dados = '0; pronto_serial = 1'b0;
      tick(2);
      reset = 1'b0;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_partida", 32'(partida_tx), 32'd0);
      chk("rst_dado", 32'(dado_tx), 32'd0);
      chk("rst_erro", 32'(erro), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_db", 32'(db_estado), 32'd0);

      // single packet from requester 0
      req = 2'b01;
      tick(1);
      chk("single_gnt", 32'(gnt), 32'b01);
      chk("single_ocupado", 32'(ocupado), 32'd1);
      send_byte(0, 8'h41, 1'b0, 10, 1'b1);
      send_byte(0, 8'h42, 1'b0, 10, 1'b1);
      send_byte(0, 8'h43, 1'b1, 10, 1'b1);
      chk("single_idle_gnt", 32'(gnt), 32'd0);
      chk("single_idle_ocupado", 32'(ocupado), 32'd0);

      // contention: both request right after reset
      reset = 1'b1; tick(2); reset = 1'b0;
      req = 2'b11;
      tick(1);
      chk("cont_first", 32'(gnt), 32'b01);
      send_byte(0, 8'hA1, 1'b1, 3, 1'b1);
      tick(1);
      chk("cont_second", 32'(gnt), 32'b10);
      req[0] = 1'b1;
      send_byte(1, 8'hB1, 1'b0, 4, 1'b0);
      send_byte(1, 8'hB2, 1'b1, 4, 1'b0);
      tick(1);
      chk("cont_third", 32'(gnt), 32'b01);
      send_byte(0, 8'hA2, 1'b1, 2, 1'b1);
      tick(1);
      chk("cont_fourth", 32'(gnt), 32'b10);
      send_byte(1, 8'hB3, 1'b1, 2, 1'b1);
      tick(1);
      chk("cont_idle", 32'(gnt), 32'd0);

      // watchdog: requester 0 never gets pronto_serial, requester 1 pending
      reset = 1'b1; tick(2); reset = 1'b0;
      req = 2'b11;
      tick(1);
      chk("to_gnt", 32'(gnt), 32'b01);
      valid[0] = 1'b1; dados[7:0] = 8'h55; ultimo[0] = 1'b0;
      tick(1);
      chk("to_partida", 32'(partida_tx), 32'd1);
      valid = '0; dados = '0;
      tick(15);
      chk("to_not_yet", 32'(erro), 32'd0);
      chk("to_still_espera", 32'(db_estado), 32'd3);
      tick(1);
      chk("to_erro", 32'(erro), 32'd1);
      chk("to_no_ack", 32'(ack), 32'd0);
      chk("to_db", 32'(db_estado), 32'd5);
      tick(1);
      chk("to_erro_single", 32'(erro), 32'd0);
      chk("to_idle", 32'(db_estado), 32'd0);
      tick(1);
      chk("to_next_owner", 32'(gnt), 32'b10);

      // withdraw: requester 1 drops req before presenting a byte
      req[1] = 1'b0;
      tick(1);
      chk("wd_idle", 32'(db_estado), 32'd0);
      chk("wd_no_partida", 32'(partida_tx), 32'd0);
      chk("wd_gnt", 32'(gnt), 32'd0);
      tick(1);
      chk("wd_req0_served", 32'(gnt), 32'b01);

      // stray pronto and non-owner valid in CONCEDE
      pronto_serial = 1'b1; valid[1] = 1'b1; dados[15:8] = 8'h99;
      tick(1);
      pronto_serial = 1'b0; valid = '0; dados = '0;
      chk("stray_c_ack", 32'(ack), 32'd0);
      chk("stray_c_db", 32'(db_estado), 32'd1);
      chk("stray_c_partida", 32'(partida_tx), 32'd0);
      // pronto_serial arriving in the watchdog's last cycle still completes the byte
      send_byte(0, 8'h66, 1'b1, 16, 1'b1);
      chk("expiry_no_erro", 32'(erro), 32'd0);
      pronto_serial = 1'b1;
      tick(1);
      pronto_serial = 1'b0;
      chk("stray_o_ack", 32'(ack), 32'd0);
      chk("stray_o_db", 32'(db_estado), 32'd0);

      // reset while in ESPERA; last-owner pointer returns to requester 0 first
      req = 2'b01;
      tick(1);
      valid[0] = 1'b1; dados[7:0] = 8'h77;
      tick(1);
      valid = '0;
      tick(3);
      chk("re_espera", 32'(db_estado), 32'd3);
      reset = 1'b1; req = 2'b11;
      tick(1);
      chk("re_gnt", 32'(gnt), 32'd0);
      chk("re_ack", 32'(ack), 32'd0);
      chk("re_partida", 32'(partida_tx), 32'd0);
      chk("re_dado", 32'(dado_tx), 32'd0);
      chk("re_erro", 32'(erro), 32'd0);
      chk("re_ocupado", 32'(ocupado), 32'd0);
      chk("re_db", 32'(db_estado), 32'd0);
      reset = 1'b0;
      tick(1);
      chk("re_req0_first", 32'(gnt), 32'b01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
